// File: rtl/tag_state_sequencer.sv
// Gen2 tag inventory/access sequencer: command-driven tag FSM, Q/slot registers and reply request handshake.
// Optional `SEQ_T2_TIMEOUT_EN adds a T2 timer that returns REPLY/ACKNOWLEDGED tags to ARBITRATE when no command follows.
module tag_state_sequencer #(
    parameter int T2_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  packettype,
    input  logic        packetdone,
    input  logic        handlematch,
    input  logic [3:0]  rx_q,
    input  logic [2:0]  rx_updn,
    input  logic [14:0] rng,
    input  logic        tx_done,
    output logic [2:0]  tagstate,
    output logic [3:0]  q_reg,
    output logic [14:0] slotctr,
    output logic        reply_req,
    output logic [2:0]  reply_type,
    output logic        rn_load,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_READY        = 3'd0,
        ST_ARBITRATE    = 3'd1,
        ST_REPLY        = 3'd2,
        ST_ACKNOWLEDGED = 3'd3,
        ST_OPEN         = 3'd4
    } state_t;

    localparam logic [2:0] RT_NONE   = 3'd0;
    localparam logic [2:0] RT_RN16   = 3'd1;
    localparam logic [2:0] RT_EPC    = 3'd2;
    localparam logic [2:0] RT_HANDLE = 3'd3;
    localparam logic [2:0] RT_RN     = 3'd4;
    localparam logic [2:0] RT_READ   = 3'd5;
    localparam logic [2:0] RT_WRITE  = 3'd6;

    localparam logic [8:0] PK_QUERYREP = 9'h001;
    localparam logic [8:0] PK_ACK      = 9'h002;
    localparam logic [8:0] PK_QUERY    = 9'h004;
    localparam logic [8:0] PK_QUERYADJ = 9'h008;
    localparam logic [8:0] PK_SELECT   = 9'h010;
    localparam logic [8:0] PK_NAK      = 9'h020;
    localparam logic [8:0] PK_REQRN    = 9'h040;
    localparam logic [8:0] PK_READ     = 9'h080;
    localparam logic [8:0] PK_WRITE    = 9'h100;

    localparam logic [14:0] SLOT_PARK = 15'h7FFF;

    if (T2_CYCLES < 1) begin : g_t2_range
        $error("T2_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [3:0]  q_q, q_d;
    logic [14:0] slot_q, slot_d;
    logic        req_q, req_d;
    logic [2:0]  rtype_q, rtype_d;
    logic        rnld_q, rnld_d;

    logic        onehot;
    logic        accept;
    logic        adj_ok;
    logic [3:0]  q_adj;
    logic [14:0] slot_dec;
    logic        in_tag_sel;

    function automatic logic [14:0] draw(input logic [3:0] q, input logic [14:0] r);
        logic [14:0] mask;
        mask = (15'd1 << q) - 15'd1;
        return r & mask;
    endfunction

    assign onehot     = (packettype != 9'd0) && ((packettype & (packettype - 9'd1)) == 9'd0);
    assign accept     = packetdone && !req_q && onehot;
    assign slot_dec   = slot_q - 15'd1;
    assign in_tag_sel = (state_q == ST_REPLY) || (state_q == ST_ACKNOWLEDGED) || (state_q == ST_OPEN);

    always_comb begin
        adj_ok = 1'b1;
        q_adj  = q_q;
        case (rx_updn)
            3'b110:  q_adj = (q_q == 4'd15) ? 4'd15 : q_q + 4'd1;
            3'b011:  q_adj = (q_q == 4'd0)  ? 4'd0  : q_q - 4'd1;
            3'b000:  q_adj = q_q;
            default: adj_ok = 1'b0;
        endcase
    end

`ifdef SEQ_T2_TIMEOUT_EN
    localparam int T2W = $clog2(T2_CYCLES + 1);
    logic           t2_run_q, t2_run_d;
    logic [T2W-1:0] t2_cnt_q, t2_cnt_d;
`endif

    always_comb begin
        logic go_reply;
        go_reply = 1'b0;
        state_d  = state_q;
        q_d      = q_q;
        slot_d   = slot_q;
        req_d    = req_q;
        rtype_d  = rtype_q;
        rnld_d   = 1'b0;
`ifdef SEQ_T2_TIMEOUT_EN
        t2_run_d = t2_run_q;
        t2_cnt_d = t2_cnt_q;
`endif

        if (req_q && tx_done) begin
            req_d   = 1'b0;
            rtype_d = RT_NONE;
        end

        if (accept) begin
            case (packettype)
                PK_SELECT: state_d = ST_READY;
                PK_QUERY: begin
                    q_d    = rx_q;
                    slot_d = draw(rx_q, rng);
                    if (draw(rx_q, rng) == 15'd0) go_reply = 1'b1;
                    else                           state_d  = ST_ARBITRATE;
                end
                PK_QUERYREP: begin
                    if (state_q == ST_ARBITRATE) begin
                        slot_d = slot_dec;
                        if (slot_dec == 15'd0) go_reply = 1'b1;
                    end else if (in_tag_sel) begin
                        state_d = ST_ARBITRATE;
                        slot_d  = SLOT_PARK;
                    end
                end
                PK_QUERYADJ: begin
                    if (adj_ok && (state_q == ST_ARBITRATE || state_q == ST_REPLY)) begin
                        q_d    = q_adj;
                        slot_d = draw(q_adj, rng);
                        if (draw(q_adj, rng) == 15'd0) go_reply = 1'b1;
                        else                            state_d  = ST_ARBITRATE;
                    end else if (adj_ok && (state_q == ST_ACKNOWLEDGED || state_q == ST_OPEN)) begin
                        state_d = ST_ARBITRATE;
                        slot_d  = SLOT_PARK;
                    end
                end
                PK_ACK: begin
                    if (in_tag_sel && handlematch) begin
                        state_d = (state_q == ST_OPEN) ? ST_OPEN : ST_ACKNOWLEDGED;
                        req_d   = 1'b1;
                        rtype_d = RT_EPC;
                    end else if (in_tag_sel) begin
                        state_d = ST_ARBITRATE;
                        slot_d  = SLOT_PARK;
                    end
                end
                PK_NAK: begin
                    if (in_tag_sel) begin
                        state_d = ST_ARBITRATE;
                        slot_d  = SLOT_PARK;
                    end
                end
                PK_REQRN: begin
                    if (handlematch && state_q == ST_ACKNOWLEDGED) begin
                        state_d = ST_OPEN;
                        req_d   = 1'b1;
                        rtype_d = RT_HANDLE;
                        rnld_d  = 1'b1;
                    end else if (handlematch && state_q == ST_OPEN) begin
                        req_d   = 1'b1;
                        rtype_d = RT_RN;
                        rnld_d  = 1'b1;
                    end
                end
                PK_READ, PK_WRITE: begin
                    if (handlematch && state_q == ST_OPEN) begin
                        req_d   = 1'b1;
                        rtype_d = (packettype == PK_READ) ? RT_READ : RT_WRITE;
                    end
                end
                default: ;
            endcase
        end

        if (go_reply) begin
            state_d = ST_REPLY;
            req_d   = 1'b1;
            rtype_d = RT_RN16;
            rnld_d  = 1'b1;
        end

`ifdef SEQ_T2_TIMEOUT_EN
        // Timer arms only for replies sent while the tag is singulated but not yet open.
        if (req_q && tx_done && (state_q == ST_REPLY || state_q == ST_ACKNOWLEDGED)) begin
            t2_run_d = 1'b1;
            t2_cnt_d = '0;
        end else if (accept) begin
            t2_run_d = 1'b0;
        end else if (t2_run_q) begin
            if (t2_cnt_q == T2W'(T2_CYCLES - 1)) begin
                t2_run_d = 1'b0;
                state_d  = ST_ARBITRATE;
                slot_d   = SLOT_PARK;
            end else begin
                t2_cnt_d = t2_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_READY;
            q_q      <= 4'd0;
            slot_q   <= 15'd0;
            req_q    <= 1'b0;
            rtype_q  <= RT_NONE;
            rnld_q   <= 1'b0;
`ifdef SEQ_T2_TIMEOUT_EN
            t2_run_q <= 1'b0;
            t2_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            slot_q   <= slot_d;
            req_q    <= req_d;
            rtype_q  <= rtype_d;
            rnld_q   <= rnld_d;
`ifdef SEQ_T2_TIMEOUT_EN
            t2_run_q <= t2_run_d;
            t2_cnt_q <= t2_cnt_d;
`endif
        end
    end

    assign tagstate   = state_q;
    assign q_reg      = q_q;
    assign slotctr    = slot_q;
    assign reply_req  = req_q;
    assign reply_type = rtype_q;
    assign rn_load    = rnld_q;
    assign busy       = req_q;

endmodule

// File: tb/tb_tag_state_sequencer.sv
// Directed bench for tag_state_sequencer: driver queues hand-computed expected snapshots, monitor checks after each event.
module tb_tag_state_sequencer;

    localparam logic [8:0] QREP = 9'h001, ACK = 9'h002, QUERY = 9'h004, QADJ = 9'h008, SEL = 9'h010;
    localparam logic [8:0] NAK = 9'h020, REQRN = 9'h040, READ = 9'h080, WRITE = 9'h100;
    localparam logic [2:0] RDY = 3'd0, ARB = 3'd1, REP = 3'd2, ACKD = 3'd3, OPN = 3'd4;
    localparam logic [2:0] NONE = 3'd0, RN16 = 3'd1, EPC = 3'd2, HNDL = 3'd3, RN = 3'd4, RDAT = 3'd5, WACK = 3'd6;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  q;
        logic [14:0] slot;
        logic        req;
        logic [2:0]  rt;
        logic        rn;
        logic        bsy;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  packettype = '0;
    logic        packetdone = 1'b0;
    logic        handlematch = 1'b0;
    logic [3:0]  rx_q = '0;
    logic [2:0]  rx_updn = '0;
    logic [14:0] rng = '0;
    logic        tx_done = 1'b0;
    logic [2:0]  tagstate;
    logic [3:0]  q_reg;
    logic [14:0] slotctr;
    logic        reply_req;
    logic [2:0]  reply_type;
    logic        rn_load;
    logic        busy;

    logic  probe = 1'b0;
    logic  evt = 1'b0;
    snap_t expq[$];
    int    compared = 0;
    int    mismatched = 0;

    tag_state_sequencer #(.T2_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .packettype(packettype), .packetdone(packetdone),
        .handlematch(handlematch), .rx_q(rx_q), .rx_updn(rx_updn), .rng(rng), .tx_done(tx_done),
        .tagstate(tagstate), .q_reg(q_reg), .slotctr(slotctr), .reply_req(reply_req),
        .reply_type(reply_type), .rn_load(rn_load), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic [2:0] st, input logic [3:0] q, input logic [14:0] slot,
                                 input logic req, input logic [2:0] rt, input logic rn);
        snap_t s;
        s = '{st: st, q: q, slot: slot, req: req, rt: rt, rn: rn, bsy: req};
        return s;
    endfunction

    // Every cycle that carries a command, tx_done or probe produces one expected snapshot.
    always @(posedge clk) evt <= packetdone | tx_done | probe;

    always @(negedge clk) begin
        if (evt) begin
            snap_t act, e;
            act = '{st: tagstate, q: q_reg, slot: slotctr, req: reply_req, rt: reply_type, rn: rn_load, bsy: busy};
            compared++;
            if (expq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event #%0d: no expectation queued, got %h", compared, act);
            end else begin
                e = expq.pop_front();
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL snapshot #%0d: got st=%0d q=%0d slot=%h req=%b rt=%0d rn=%b busy=%b, want st=%0d q=%0d slot=%h req=%b rt=%0d rn=%b busy=%b",
                             compared, act.st, act.q, act.slot, act.req, act.rt, act.rn, act.bsy,
                             e.st, e.q, e.slot, e.req, e.rt, e.rn, e.bsy);
                end
            end
        end
    end

    task automatic cmd(input logic [8:0] pt, input logic hm, input logic [3:0] q, input logic [2:0] ud,
                       input logic [14:0] r, input logic tx, input snap_t e);
        packettype = pt; handlematch = hm; rx_q = q; rx_updn = ud; rng = r;
        packetdone = 1'b1; tx_done = tx;
        expq.push_back(e);
        @(posedge clk); #1;
        packetdone = 1'b0; packettype = '0; tx_done = 1'b0;
    endtask

    task automatic txd(input snap_t e);
        tx_done = 1'b1;
        expq.push_back(e);
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic chk(input snap_t e);
        probe = 1'b1;
        expq.push_back(e);
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        gap(3);
        reset = 1'b0;
        chk(mk(RDY, 0, 15'h0000, 0, NONE, 0));

        // QUERY Q=0 lands in slot 0 immediately.
        cmd(QUERY, 0, 4'd0, 3'd0, 15'h1234, 0, mk(REP, 0, 15'h0000, 1, RN16, 1));
        chk(mk(REP, 0, 15'h0000, 1, RN16, 0));
        cmd(QUERY, 0, 4'd5, 3'd0, 15'h0000, 0, mk(REP, 0, 15'h0000, 1, RN16, 0));
        cmd(QUERY, 0, 4'd3, 3'd0, 15'h0006, 1, mk(REP, 0, 15'h0000, 0, NONE, 0));
        cmd(QUERY, 0, 4'd3, 3'd0, 15'h0006, 0, mk(ARB, 3, 15'h0006, 0, NONE, 0));

        for (int i = 5; i >= 1; i--) begin
            cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(ARB, 3, 15'(i), 0, NONE, 0));
            gap(1);
        end
        cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(REP, 3, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 3, 15'h0000, 0, NONE, 0));

        cmd(ACK, 1, 4'd0, 3'd0, 15'h0000, 0, mk(ACKD, 3, 15'h0000, 1, EPC, 0));
        txd(mk(ACKD, 3, 15'h0000, 0, NONE, 0));
        cmd(REQRN, 1, 4'd0, 3'd0, 15'h0000, 0, mk(OPN, 3, 15'h0000, 1, HNDL, 1));
        txd(mk(OPN, 3, 15'h0000, 0, NONE, 0));
        cmd(READ, 1, 4'd0, 3'd0, 15'h0000, 0, mk(OPN, 3, 15'h0000, 1, RDAT, 0));
        txd(mk(OPN, 3, 15'h0000, 0, NONE, 0));
        cmd(READ, 0, 4'd0, 3'd0, 15'h0000, 0, mk(OPN, 3, 15'h0000, 0, NONE, 0));
        cmd(WRITE, 1, 4'd0, 3'd0, 15'h0000, 0, mk(OPN, 3, 15'h0000, 1, WACK, 0));
        txd(mk(OPN, 3, 15'h0000, 0, NONE, 0));
        cmd(REQRN, 1, 4'd0, 3'd0, 15'h0000, 0, mk(OPN, 3, 15'h0000, 1, RN, 1));
        txd(mk(OPN, 3, 15'h0000, 0, NONE, 0));
        cmd(ACK, 0, 4'd0, 3'd0, 15'h0000, 0, mk(ARB, 3, 15'h7FFF, 0, NONE, 0));
        cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(ARB, 3, 15'h7FFE, 0, NONE, 0));

        // Q saturation edges and an illegal up/down code.
        cmd(QUERY, 0, 4'd15, 3'd0, 15'h7FFF, 0, mk(ARB, 15, 15'h7FFF, 0, NONE, 0));
        cmd(QADJ, 0, 4'd0, 3'b110, 15'h0000, 0, mk(REP, 15, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 15, 15'h0000, 0, NONE, 0));
        cmd(QADJ, 0, 4'd0, 3'b101, 15'h1111, 0, mk(REP, 15, 15'h0000, 0, NONE, 0));
        cmd(QADJ, 0, 4'd0, 3'b011, 15'h0005, 0, mk(ARB, 14, 15'h0005, 0, NONE, 0));
        cmd(QUERY, 0, 4'd0, 3'd0, 15'h7FFF, 0, mk(REP, 0, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 0, 15'h0000, 0, NONE, 0));
        cmd(QADJ, 0, 4'd0, 3'b011, 15'h0003, 0, mk(REP, 0, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 0, 15'h0000, 0, NONE, 0));
        cmd(NAK, 0, 4'd0, 3'd0, 15'h0000, 0, mk(ARB, 0, 15'h7FFF, 0, NONE, 0));
        cmd(9'h006, 1, 4'd2, 3'd0, 15'h0000, 0, mk(ARB, 0, 15'h7FFF, 0, NONE, 0));

        cmd(QUERY, 0, 4'd1, 3'd0, 15'h0001, 0, mk(ARB, 1, 15'h0001, 0, NONE, 0));
        cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(REP, 1, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 1, 15'h0000, 0, NONE, 0));
        cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(ARB, 1, 15'h7FFF, 0, NONE, 0));
        cmd(SEL, 0, 4'd0, 3'd0, 15'h0000, 0, mk(RDY, 1, 15'h7FFF, 0, NONE, 0));
        cmd(QREP, 0, 4'd0, 3'd0, 15'h0000, 0, mk(RDY, 1, 15'h7FFF, 0, NONE, 0));

        // Reset while a reply is pending, then a stale tx_done.
        cmd(QUERY, 0, 4'd0, 3'd0, 15'h0000, 0, mk(REP, 0, 15'h0000, 1, RN16, 1));
        reset = 1'b1;
        chk(mk(RDY, 0, 15'h0000, 0, NONE, 0));
        reset = 1'b0;
        txd(mk(RDY, 0, 15'h0000, 0, NONE, 0));

        // T2 window: still REPLY one cycle before expiry.
        cmd(QUERY, 0, 4'd0, 3'd0, 15'h0000, 0, mk(REP, 0, 15'h0000, 1, RN16, 1));
        txd(mk(REP, 0, 15'h0000, 0, NONE, 0));
        gap(8);
        chk(mk(REP, 0, 15'h0000, 0, NONE, 0));
`ifdef SEQ_T2_TIMEOUT_EN
        chk(mk(ARB, 0, 15'h7FFF, 0, NONE, 0));
`else
        chk(mk(REP, 0, 15'h0000, 0, NONE, 0));
`endif

        gap(3);
        if (expq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL leftover_expectations: got %0d unchecked, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tag_state_sequencer.md
# tag_state_sequencer

Gen2 tag inventory/access controller sitting behind the packet parser. On each parsed-command strobe it consumes the command type, handle-match result and Q / up-down fields. It advances the tag state machine, Q register and slot counter, and issues one reply request per command to the transmit path. It also tells the RN generator when to latch a fresh RN16/handle.

## Interface
Parameters:
- T2_CYCLES, 20000: clk cycles after tx_done before an unanswered reply times out. Used only with SEQ_T2_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, all state on rising edge of clk
- packettype  in  9  one-hot command type, valid when packetdone=1:
  - b0 QUERYREP, b1 ACK, b2 QUERY, b3 QUERYADJ, b4 SELECT, b5 NAK, b6 REQRN, b7 READ, b8 WRITE
- packetdone  in  1  one-cycle strobe: command fully parsed, CRC good, fields valid
- handlematch  in  1  handle comparison passed (valid with packetdone)
- rx_q  in  4  Q from QUERY
- rx_updn  in  3  QUERYADJ field
- rng  in  15  free-running random value
- tx_done  in  1  one-cycle strobe: transmitter finished current reply
- tagstate  out  3  0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED, 4 OPEN
- q_reg  out  4  current Q
- slotctr  out  15  slot counter
- reply_req  out  1  reply pending; held until tx_done
- reply_type  out  3  0 NONE, 1 RN16, 2 EPC, 3 HANDLE, 4 RN, 5 READDATA, 6 WRITEACK; stable while reply_req=1
- rn_load  out  1  one-cycle pulse: RN generator latches new RN16/handle
- busy  out  1  equals reply_req

## Operation
- Reset values: tagstate READY, q_reg 0, slotctr 0, reply_req 0, reply_type NONE, rn_load 0, busy 0.
- Commands are accepted only when packetdone=1, busy=0, and packettype has exactly one bit set. All other cycles leave state unchanged, including zero or multi-hot packettype and packetdone while busy.
- Slot draw: slotctr = rng & ((1<<Q)-1), with Q the value in effect after the command. Q=0 gives slotctr 0.
- A transition to REPLY always sets reply_type RN16, raises reply_req and pulses rn_load.
- SELECT: any state -> READY. No reply.
- QUERY: any state.
  - q_reg <= rx_q, then slot draw.
  - Slot 0 -> REPLY; else -> ARBITRATE.
- QUERYREP:
  - ARBITRATE: slotctr-1, wrapping 0 -> 0x7FFF. New value 0 -> REPLY; else stay.
  - REPLY, ACKNOWLEDGED, OPEN: -> ARBITRATE, slotctr 0x7FFF.
  - READY: ignored.
- QUERYADJ:
  - rx_updn 110: Q+1, saturating at 15.
  - rx_updn 011: Q-1, saturating at 0.
  - rx_updn 000: Q unchanged.
  - Any other rx_updn value: command ignored.
  - In ARBITRATE or REPLY: apply the Q change, redraw the slot, then slot 0 -> REPLY, else -> ARBITRATE.
  - In ACKNOWLEDGED or OPEN: -> ARBITRATE, slotctr 0x7FFF, Q unchanged.
- ACK:
  - REPLY or ACKNOWLEDGED, handlematch=1: -> ACKNOWLEDGED, reply EPC.
  - OPEN, handlematch=1: stay OPEN, reply EPC.
  - handlematch=0 in REPLY, ACKNOWLEDGED or OPEN: -> ARBITRATE, slotctr 0x7FFF.
- NAK: REPLY, ACKNOWLEDGED or OPEN -> ARBITRATE, slotctr 0x7FFF.
- REQRN, handlematch=1:
  - ACKNOWLEDGED: -> OPEN, reply HANDLE, pulse rn_load.
  - OPEN: reply RN, pulse rn_load.
  - Mismatch: ignored.
- READ / WRITE: OPEN with handlematch=1 -> reply READDATA / WRITEACK. Otherwise ignored.
- Commands valid in the current state but not listed above are ignored.

## Timing
- packetdone sampled in cycle N: tagstate, q_reg, slotctr, reply_req, reply_type and rn_load update at edge N+1.
- rn_load is high for cycle N+1 only.
- tx_done sampled in cycle M: reply_req=0 and reply_type=NONE at M+1.
  - A packetdone in cycle M is dropped, because busy=1 in cycle M.
  - A packetdone in cycle M+1 is accepted.
- tx_done while reply_req=0 is ignored.
- Reset mid-reply: reply_req drops at the next edge. A later tx_done is ignored.

## Configuration
- SEQ_T2_TIMEOUT_EN defined:
  - A T2 counter starts on the edge at which tx_done is sampled, for replies issued from REPLY or ACKNOWLEDGED.
  - If no command is accepted within T2_CYCLES cycles, tagstate -> ARBITRATE and slotctr -> 0x7FFF.
  - Any accepted command stops the counter.
- SEQ_T2_TIMEOUT_EN undefined: no counter; REPLY and ACKNOWLEDGED persist indefinitely.

## Test plan
- Reset, then QUERY with rx_q=0 -> next cycle: tagstate REPLY, q_reg 0, slotctr 0, reply_req 1, reply_type RN16, rn_load pulse.
- QUERY with rx_q=3, rng=0x0006 -> ARBITRATE, slotctr 6. Six QUERYREPs, each followed by an idle gap -> REPLY on the sixth, with reply RN16.
- From REPLY: ACK with handlematch=1 -> ACKNOWLEDGED/EPC. tx_done, then REQRN with match -> OPEN/HANDLE. READ with match -> READDATA. READ with handlematch=0 -> no reply.
- q_reg=15: QUERYADJ 110 -> q_reg stays 15. rx_updn=101 -> no change at all. q_reg=0: QUERYADJ 011 -> q_reg stays 0.
- QUERY while reply_req=1 -> ignored. QUERY on the same cycle as tx_done -> ignored, reply_req drops. QUERY one cycle later -> accepted. Multi-hot packettype 0x006 -> ignored.
- With SEQ_T2_TIMEOUT_EN and T2_CYCLES=10: RN16 reply, then tx_done, then 10 idle cycles -> ARBITRATE, slotctr 0x7FFF. Without the macro -> stays REPLY.
